// File: rtl/serial_bit_feeder.sv
// Double-buffered parallel-to-serial stage: words arrive over valid/ready into a
// holding register and are shifted out MSB first, one bit every BIT_PERIOD cycles.
//
// state | meaning
// IDLE  | shift register empty; waits for the holding register to fill
// SHIFT | a word is being serialized; strobes every BIT_PERIOD cycles
module serial_bit_feeder #(
  parameter int WIDTH      = 8,
  parameter int BIT_PERIOD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);
  localparam int PW = $clog2(BIT_PERIOD + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [PW-1:0] LAST_PRE = PW'(BIT_PERIOD - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full;
  logic [BW-1:0]    bit_cnt;
  logic [PW-1:0]    pre_cnt;
  logic             strobe;
  logic             last_bit;

  assign strobe   = (state == SHIFT) && (pre_cnt == LAST_PRE);
  assign last_bit = (bit_cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      pre_cnt   <= '0;
    end else begin
      // Accept and transfer never coincide: accept needs hold_full low, transfer needs it high.
      if (din_valid && !hold_full) begin
        hold_reg  <= din;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (hold_full) begin
            shift_reg <= hold_reg;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            pre_cnt   <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (!strobe) begin
            pre_cnt <= pre_cnt + PW'(1);
          end else if (!last_bit) begin
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            bit_cnt   <= bit_cnt + BW'(1);
            pre_cnt   <= '0;
          end else if (hold_full) begin
            // Gapless hand-off: the next word's MSB follows on the very next bit slot.
            shift_reg <= hold_reg;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            pre_cnt   <= '0;
          end else begin
            bit_cnt <= '0;
            pre_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so nothing depends on din_valid combinationally.
  assign din_ready  = ~hold_full;
  assign sout       = (state == SHIFT) ? shift_reg[WIDTH-1] : 1'b0;
  assign sout_valid = strobe;
  assign done       = strobe && last_bit;
  assign busy       = (state == SHIFT) || hold_full;

endmodule
